// File: rtl/dmem_responder_if.sv
// Request/response bus between the execute stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] daddr;
  logic [3:0]  dwe;
  logic [31:0] dwdata;
  logic        rsp_valid;
  logic [31:0] drdata;
  logic        err;

  modport master (
    output req_valid, daddr, dwe, dwdata,
    input  req_ready, rsp_valid, drdata, err
  );

  modport slave (
    input  req_valid, daddr, dwe, dwdata,
    output req_ready, rsp_valid, drdata, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM behind a valid/ready request with programmable wait states,
// byte-lane store steering and range/enable-pattern error reporting.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  dwe_q, dwe_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        err_q, err_d;
  logic        rd_ok_q, rd_ok_d;
  logic [31:0] rd_q;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic [31:0]           op_addr, op_data, steer;
  logic [3:0]            op_dwe;
  logic [ADDR_WIDTH-1:0] op_idx;
  logic                  op_legal, op_err, go_resp, mem_we;

  // With zero wait states the access happens on the accept edge, so use the live inputs.
  always_comb begin
    if (state_q == StIdle) begin
      op_addr = bus.daddr;
      op_dwe  = bus.dwe;
      op_data = bus.dwdata;
    end else begin
      op_addr = addr_q;
      op_dwe  = dwe_q;
      op_data = wdata_q;
    end
  end

  assign op_idx = op_addr[ADDR_WIDTH+1:2];

  always_comb begin
    op_legal = 1'b0;
    case (op_dwe)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: op_legal = 1'b1;
      default:                   op_legal = 1'b0;
    endcase
  end

  assign op_err = ((op_addr >> (ADDR_WIDTH + 2)) != 32'd0) || !op_legal;

  // Replicate right-justified data across lanes; the enables pick which copy lands.
  always_comb begin
    steer = {4{op_data[7:0]}};
    case (op_dwe)
      4'b1111:          steer = op_data;
      4'b0011, 4'b1100: steer = {2{op_data[15:0]}};
      default:          steer = {4{op_data[7:0]}};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dwe_d   = dwe_q;
    wdata_d = wdata_q;
    go_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          addr_d  = bus.daddr;
          dwe_d   = bus.dwe;
          wdata_d = bus.dwdata;
          cnt_d   = 4'(WAIT_STATES);
          if (WAIT_STATES > 0) begin
            state_d = StWait;
          end else begin
            state_d = StResp;
            go_resp = 1'b1;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StResp;
          go_resp = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign rsp_valid_d = go_resp;
  assign err_d       = go_resp && op_err;
  assign rd_ok_d     = go_resp && !op_err && (op_dwe == 4'b0000);
  // Gate with reset so an aborted transaction can never commit its store.
  assign mem_we      = go_resp && !op_err && (op_dwe != 4'b0000) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      addr_q      <= 32'd0;
      dwe_q       <= 4'd0;
      wdata_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      dwe_q       <= dwe_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      rd_ok_q     <= rd_ok_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && op_dwe[b]) begin
        mem[op_idx][8*b +: 8] <= steer[8*b +: 8];
      end
    end
    rd_q <= mem[op_idx];
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.err       = err_q;
  assign bus.drdata    = rd_ok_q ? rd_q : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: directed vector table, reset/back-to-back sequences and a
// randomized run against a byte-level memory model.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst1, rst0;
  always #5 clk = ~clk;

  dmem_responder_if bus1 ();
  dmem_responder_if bus0 ();

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (bus1)
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
    .clk   (clk),
    .reset (rst0),
    .bus   (bus0)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  dwe;
    logic [31:0] data;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs[18];
  logic [31:0] model[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One transaction on the WAIT_STATES=1 instance; lat counts cycles after the accept cycle.
  task automatic txn1(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d,
                      output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk);
    bus1.req_valid = 1'b1;
    bus1.daddr     = a;
    bus1.dwe       = we;
    bus1.dwdata    = d;
    @(posedge clk);
    #1;
    bus1.req_valid = 1'b0;
    lat = 1;
    rd  = 32'd0;
    e   = 1'b0;
    @(negedge clk);
    while (!bus1.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (bus1.rsp_valid) begin
      rd = bus1.drdata;
      e  = bus1.err;
      check("ready_low_in_resp", 32'(bus1.req_ready), 32'd0);
    end else begin
      lat = -1;
    end
  endtask

  function automatic logic legal(input logic [3:0] we);
    return we inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a, d, sh, exp_rd;
    logic [3:0]  we;
    logic        e, exp_err;
    int          lat, lowest, accepts;

    rst1 = 1'b1;
    rst0 = 1'b1;
    bus1.req_valid = 1'b0; bus1.daddr = '0; bus1.dwe = '0; bus1.dwdata = '0;
    bus0.req_valid = 1'b0; bus0.daddr = '0; bus0.dwe = '0; bus0.dwdata = '0;
    #1;
    check("rst_ready",  32'(bus1.req_ready), 32'd1);
    check("rst_rsp",    32'(bus1.rsp_valid), 32'd0);
    check("rst_err",    32'(bus1.err),       32'd0);
    check("rst_drdata", bus1.drdata,         32'd0);
    repeat (2) @(negedge clk);
    rst1 = 1'b0;
    rst0 = 1'b0;

    vecs[0]  = '{32'h10,   4'b1111, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{32'h10,   4'b0000, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{32'h10,   4'b0010, 32'h000000A5, 1'b0, 32'h0};
    vecs[3]  = '{32'h10,   4'b0000, 32'h0,        1'b0, 32'hDEADA5EF};
    vecs[4]  = '{32'h10,   4'b1100, 32'h00001234, 1'b0, 32'h0};
    vecs[5]  = '{32'h10,   4'b0000, 32'h0,        1'b0, 32'h1234A5EF};
    vecs[6]  = '{32'h10,   4'b0101, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[7]  = '{32'h10,   4'b0000, 32'h0,        1'b0, 32'h1234A5EF};
    vecs[8]  = '{32'h13,   4'b0001, 32'hFFFFFF77, 1'b0, 32'h0};
    vecs[9]  = '{32'h10,   4'b0000, 32'h0,        1'b0, 32'h1234A577};
    vecs[10] = '{32'hFFC,  4'b1111, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[11] = '{32'hFFC,  4'b0000, 32'h0,        1'b0, 32'hCAFEF00D};
    vecs[12] = '{32'h0,    4'b1111, 32'h01020304, 1'b0, 32'h0};
    vecs[13] = '{32'h1000, 4'b0000, 32'h0,        1'b1, 32'h0};
    vecs[14] = '{32'h1000, 4'b1111, 32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[15] = '{32'h0,    4'b0000, 32'h0,        1'b0, 32'h01020304};
    vecs[16] = '{32'h20,   4'b1111, 32'h11111111, 1'b0, 32'h0};
    vecs[17] = '{32'h20,   4'b0000, 32'h0,        1'b0, 32'h11111111};

    for (int i = 0; i < 18; i++) begin
      txn1(vecs[i].addr, vecs[i].dwe, vecs[i].data, rd, e, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      check($sformatf("vec%0d_err", i),     32'(e),   32'(vecs[i].exp_err));
      check($sformatf("vec%0d_drdata", i),  rd,       vecs[i].exp_rd);
    end

    // Reset while waiting on a write: no response, no commit.
    @(negedge clk);
    bus1.req_valid = 1'b1;
    bus1.daddr     = 32'h20;
    bus1.dwe       = 4'b1111;
    bus1.dwdata    = 32'h22222222;
    @(posedge clk);
    #1;
    bus1.req_valid = 1'b0;
    check("wait_ready_low", 32'(bus1.req_ready), 32'd0);
    rst1 = 1'b1;
    #1;
    check("abort_ready",  32'(bus1.req_ready), 32'd1);
    check("abort_rsp",    32'(bus1.rsp_valid), 32'd0);
    check("abort_err",    32'(bus1.err),       32'd0);
    check("abort_drdata", bus1.drdata,         32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(bus1.rsp_valid), 32'd0);
    end
    rst1 = 1'b0;
    txn1(32'h20, 4'b0000, 32'h0, rd, e, lat);
    check("abort_readback", rd, 32'h11111111);
    check("abort_readback_err", 32'(e), 32'd0);

    // Zero wait states with req_valid held: accept on every other cycle.
    @(negedge clk);
    bus0.req_valid = 1'b1;
    bus0.daddr     = 32'h40;
    bus0.dwe       = 4'b1111;
    bus0.dwdata    = 32'h5A5A0F0F;
    accepts = 0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("b2b%0d_ready", i), 32'(bus0.req_ready), 32'((i % 2) == 0));
      check($sformatf("b2b%0d_rsp", i),   32'(bus0.rsp_valid), 32'((i % 2) == 1));
      if (bus0.req_ready && bus0.req_valid) accepts++;
      @(negedge clk);
    end
    bus0.req_valid = 1'b0;
    check("b2b_accepts", 32'(accepts), 32'd3);
    @(negedge clk);
    bus0.req_valid = 1'b1;
    bus0.dwe       = 4'b0000;
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    @(negedge clk);
    check("ws0_rsp",    32'(bus0.rsp_valid), 32'd1);
    check("ws0_drdata", bus0.drdata,         32'h5A5A0F0F);
    check("ws0_err",    32'(bus0.err),       32'd0);

    // Randomized run over an 8-word window, plus out-of-range and illegal enables.
    for (int w = 0; w < 8; w++) begin
      d = $urandom;
      model[w] = d;
      txn1(32'h400 + 32'(4 * w), 4'b1111, d, rd, e, lat);
    end
    for (int n = 0; n < 150; n++) begin
      we = 4'($urandom_range(0, 15));
      d  = $urandom;
      if ($urandom_range(0, 9) == 0) a = 32'h400 | (32'h1 << $urandom_range(12, 31));
      else                           a = 32'h400 + 32'($urandom_range(0, 31));
      exp_err = ((a >> 12) != 0) || !legal(we);
      exp_rd  = 32'd0;
      if (!exp_err) begin
        if (we == 4'b0000) begin
          exp_rd = model[(a >> 2) & 7];
        end else begin
          lowest = 0;
          while (!we[lowest]) lowest++;
          sh = d << (8 * lowest);
          for (int b = 0; b < 4; b++)
            if (we[b]) model[(a >> 2) & 7][8*b +: 8] = sh[8*b +: 8];
        end
      end
      txn1(a, we, d, rd, e, lat);
      check($sformatf("rnd%0d_latency", n), 32'(lat), 32'd2);
      check($sformatf("rnd%0d_err", n),     32'(e),   32'(exp_err));
      check($sformatf("rnd%0d_drdata", n),  rd,       exp_rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
